// File: rtl/demux4_serial_dispatcher.sv
// Serial front end for a 4-way demultiplexer. It decodes framed bits (a 2-bit channel
// address followed by payload) into a registered data bit and a registered channel select.
module demux4_serial_dispatcher #(
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din,
    input  logic       abort,
    output logic       d,
    output logic [1:0] s,
    output logic       active,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_HI = 2'd1,
        ST_ADDR_LO = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BITS - 1);

    state_t     state_r, state_s;
    logic       addr_hi_r, addr_hi_s;
    logic [7:0] cnt_r, cnt_s;
    logic       d_r, d_s;
    logic [1:0] s_r, s_s;
    logic       active_r, active_s;
    logic       done_r, done_s;

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_hi_r <= 1'b0;
            cnt_r     <= 8'd0;
            d_r       <= 1'b0;
            s_r       <= 2'b00;
            active_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_hi_r <= addr_hi_s;
            cnt_r     <= cnt_s;
            d_r       <= d_s;
            s_r       <= s_s;
            active_r  <= active_s;
            done_r    <= done_s;
        end
    end

    // Next-state and next-output logic; abort wins over start and frame completion.
    always_comb begin
        state_s   = state_r;
        addr_hi_s = addr_hi_r;
        cnt_s     = cnt_r;
        s_s       = s_r;
        d_s       = 1'b0;
        active_s  = 1'b0;
        done_s    = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_ADDR_HI;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ADDR_HI: begin
                    addr_hi_s = din;
                    state_s   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    // Both select bits load together so the demux never sees a stray channel.
                    s_s     = {addr_hi_r, din};
                    cnt_s   = 8'd0;
                    state_s = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    d_s      = din;
                    active_s = 1'b1;
                    cnt_s    = cnt_r + 8'd1;
                    if (cnt_r == LAST_IDX) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end
            endcase
        end
    end

    assign d          = d_r;
    assign s          = s_r;
    assign active     = active_r;
    assign frame_done = done_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: doc/demux4_serial_dispatcher.md
Name: demux4_serial_dispatcher

Overview:
Sequential front end for the 4-way demultiplexer stage. It receives a framed serial bit stream and drives the demux's `d` data input and 2-bit `s` select. Each frame carries a 2-bit channel address followed by PAYLOAD_BITS payload bits. Outside a frame's payload, `d` is held at 0, so every demux output stays at 0 between frames.

Parameters:
PAYLOAD_BITS, 8, payload bits per frame (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start strobe, sampled in IDLE only
din  input  1  serial frame bits: addr[1], addr[0], then payload in arrival order
abort  input  1  synchronous frame abort
d  output  1  registered payload bit to demux data input
s  output  2  registered channel select to demux select input
active  output  1  high while `d` carries a payload bit
frame_done  output  1  one-cycle pulse coincident with the last payload bit on `d`
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: state=IDLE, d=0, s=2'b00, active=0, frame_done=0, bit counter=0. Reset asserted mid-frame abandons the frame immediately.
- State machine: IDLE -> ADDR_HI -> ADDR_LO -> PAYLOAD -> IDLE.
  - IDLE: `start`=1 at an edge -> ADDR_HI. `din` is don't-care on the start cycle.
  - ADDR_HI: sample `din` into an internal addr_hi flop -> ADDR_LO.
  - ADDR_LO: at the sampling edge, s <= {addr_hi, din} as a single 2-bit load, so `s` never takes an intermediate value. Counter <= 0 -> PAYLOAD.
  - PAYLOAD: each edge, d <= din, active <= 1, counter increments. On the edge sampling bit PAYLOAD_BITS-1: frame_done <= 1 and state -> IDLE.
- Timing: start edge at cycle T; addr bits sampled at T+1 and T+2; payload sampled at T+3 .. T+2+PAYLOAD_BITS.
  - `s` changes at edge T+2, one cycle before the first payload bit appears on `d`.
  - `d` lags `din` by one cycle. The new `s` is therefore stable for the full payload window.
- Outside PAYLOAD sampling edges: d <= 0, active <= 0, frame_done <= 0.
- `s` holds its last loaded value indefinitely, across idle periods and aborts, until the next ADDR_LO load.
- Back-to-back frames: `start` is accepted in the first IDLE cycle after the last payload bit. Minimum frame period is PAYLOAD_BITS+3 cycles.
- `start` while not IDLE: ignored, with no side effect.
- `abort`=1 at an edge in any state: state -> IDLE, d <= 0, active <= 0, frame_done <= 0, counter <= 0.
  - `s` is not changed by abort.
  - An abort in ADDR_LO suppresses that edge's `s` load.
  - `abort` has priority over `start` and over PAYLOAD completion: no frame_done is issued.
- Counter width is 8 bits. Comparison is against PAYLOAD_BITS-1. No wrap is possible within the legal range.
- `busy` is combinational from state: 1 in ADDR_HI, ADDR_LO and PAYLOAD.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high, with start=0 for 10 cycles -> d=0, s=00, active=0, frame_done=0, busy=0 throughout.
- Single frame, PAYLOAD_BITS=8: start, then din = 1,0 then 1,1,0,1,0,0,1,1 -> s=10 from the cycle after the addr-lo edge; d=1,1,0,1,0,0,1,1 with active=1 for exactly 8 cycles; frame_done high only with the final 1; downstream demux shows the data only on y2.
- Back-to-back frames: addr 11 with payload 0xFF, start asserted in the first IDLE cycle, then addr 01 with payload 0xAA -> s goes 11 then 01; one IDLE gap cycle between active windows; two frame_done pulses 11 cycles apart.
- Abort mid-payload: frame addr 01, abort after the 3rd payload bit -> active drops at the next edge; d=0; no frame_done; s stays 01; next start is accepted normally.
- Abort in ADDR_LO: previous s=11, new frame addr 00 aborted at the addr-lo edge -> s remains 11, state IDLE.
- Ignored start and async reset: pulse start during PAYLOAD -> frame unaffected. Drop rst_n mid-payload between clock edges -> d, s, active and busy go to 0 immediately, without waiting for a clock edge.
